// File: rtl/rvv_backend_dispatch_raw_tracker_if.sv
// rvv_backend_dispatch_raw_tracker_if: dispatch, writeback and retire signals of the RAW tracker
interface rvv_backend_dispatch_raw_tracker_if #(
    parameter int ROB_DEPTH = 8,
    parameter int VREG_W    = 5
);
    logic                 flush;
    logic                 disp_valid;
    logic                 disp_ready;
    logic [VREG_W-1:0]    disp_vs1_idx;
    logic [VREG_W-1:0]    disp_vs2_idx;
    logic [VREG_W-1:0]    disp_vd_idx;
    logic                 disp_vs1_en;
    logic                 disp_vs2_en;
    logic                 disp_vd_rd;
    logic                 disp_v0_en;
    logic                 disp_vd_wr;
    logic [2:0]           disp_rob_idx;
    logic [ROB_DEPTH-1:0] vs1_hit;
    logic [ROB_DEPTH-1:0] vs2_hit;
    logic [ROB_DEPTH-1:0] vd_hit;
    logic [ROB_DEPTH-1:0] v0_hit;
    logic                 wb_valid;
    logic [2:0]           wb_idx;
    logic                 retire_valid;
    logic [2:0]           retire_idx;
    logic [VREG_W-1:0]    retire_vd_idx;
    logic                 retire_vd_wr;
    logic                 retire_ready;
    logic                 full;
    logic                 empty;
    logic [3:0]           count;

    modport slave (
        input  flush, disp_valid, disp_vs1_idx, disp_vs2_idx, disp_vd_idx,
               disp_vs1_en, disp_vs2_en, disp_vd_rd, disp_v0_en, disp_vd_wr,
               wb_valid, wb_idx, retire_ready,
        output disp_ready, disp_rob_idx, vs1_hit, vs2_hit, vd_hit, v0_hit,
               retire_valid, retire_idx, retire_vd_idx, retire_vd_wr, full, empty, count
    );

    modport master (
        output flush, disp_valid, disp_vs1_idx, disp_vs2_idx, disp_vd_idx,
               disp_vs1_en, disp_vs2_en, disp_vd_rd, disp_v0_en, disp_vd_wr,
               wb_valid, wb_idx, retire_ready,
        input  disp_ready, disp_rob_idx, vs1_hit, vs2_hit, vd_hit, v0_hit,
               retire_valid, retire_idx, retire_vd_idx, retire_vd_wr, full, empty, count
    );
endinterface

// File: rtl/rvv_backend_dispatch_raw_tracker.sv
// rvv_backend_dispatch_raw_tracker: in-order ROB allocator with age-ordered RAW hit vectors
// Hit bit k names age slot k (entry head+k); the youngest matching producer wins.
module rvv_backend_dispatch_raw_tracker #(
    parameter int ROB_DEPTH = 8,
    parameter int VREG_W    = 5
) (
    input logic clk,
    input logic rst_n,
    rvv_backend_dispatch_raw_tracker_if.slave bus
);
    logic [2:0]           r_head;
    logic [2:0]           r_tail;
    logic [3:0]           r_count;
    logic [ROB_DEPTH-1:0] r_valid;
    logic [ROB_DEPTH-1:0] r_done;
    logic [ROB_DEPTH-1:0] r_vd_wr;
    logic [VREG_W-1:0]    r_vd_idx [ROB_DEPTH];

    logic [2:0]           w_ent    [ROB_DEPTH];
    logic [VREG_W-1:0]    w_svd    [ROB_DEPTH];
    logic [ROB_DEPTH-1:0] w_elig;
    logic [ROB_DEPTH-1:0] w_sdone;
    logic [ROB_DEPTH-1:0] w_m_vs1;
    logic [ROB_DEPTH-1:0] w_m_vs2;
    logic [ROB_DEPTH-1:0] w_m_vd;
    logic [ROB_DEPTH-1:0] w_m_v0;
    logic                 w_full;
    logic                 w_raw_stall;
    logic                 w_alloc;
    logic                 w_retire_valid;
    logic                 w_retire;

    function automatic logic [ROB_DEPTH-1:0] f_youngest(input logic [ROB_DEPTH-1:0] m);
        f_youngest = '0;
        for (int k = 0; k < ROB_DEPTH; k++) begin
            if (m[k]) begin
                f_youngest    = '0;
                f_youngest[k] = 1'b1;
            end
        end
    endfunction

    // Rotate entry state into age order so slot 0 is always the oldest.
    for (genvar g = 0; g < ROB_DEPTH; g++) begin : g_slot
        assign w_ent[g]   = r_head + 3'(g);
        assign w_svd[g]   = r_vd_idx[w_ent[g]];
        assign w_sdone[g] = r_done[w_ent[g]];
        assign w_elig[g]  = (4'(g) < r_count) && r_valid[w_ent[g]] && r_vd_wr[w_ent[g]];
        assign w_m_vs1[g] = w_elig[g] && bus.disp_vs1_en && (w_svd[g] == bus.disp_vs1_idx);
        assign w_m_vs2[g] = w_elig[g] && bus.disp_vs2_en && (w_svd[g] == bus.disp_vs2_idx);
        assign w_m_vd[g]  = w_elig[g] && bus.disp_vd_rd  && (w_svd[g] == bus.disp_vd_idx);
        assign w_m_v0[g]  = w_elig[g] && bus.disp_v0_en  && (w_svd[g] == '0);
    end

    assign bus.vs1_hit = f_youngest(w_m_vs1);
    assign bus.vs2_hit = f_youngest(w_m_vs2);
    assign bus.vd_hit  = f_youngest(w_m_vd);
    assign bus.v0_hit  = f_youngest(w_m_v0);

    assign w_raw_stall    = |((bus.vs1_hit | bus.vs2_hit | bus.vd_hit | bus.v0_hit) & ~w_sdone);
    assign w_full         = (r_count == 4'd8);
    assign bus.disp_ready = !w_full && !w_raw_stall && !bus.flush;
    assign w_alloc        = bus.disp_valid && bus.disp_ready;
    assign w_retire_valid = r_valid[r_head] && r_done[r_head];
    assign w_retire       = w_retire_valid && bus.retire_ready;

    assign bus.disp_rob_idx  = r_tail;
    assign bus.retire_valid  = w_retire_valid;
    assign bus.retire_idx    = r_head;
    assign bus.retire_vd_idx = r_vd_idx[r_head];
    assign bus.retire_vd_wr  = r_vd_wr[r_head];
    assign bus.full          = w_full;
    assign bus.empty         = (r_count == 4'd0);
    assign bus.count         = r_count;

    // Alloc and retire never touch the same entry: alloc needs !full, retire needs a valid head.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_head   <= '0;
            r_tail   <= '0;
            r_count  <= '0;
            r_valid  <= '0;
            r_done   <= '0;
            r_vd_wr  <= '0;
            for (int k = 0; k < ROB_DEPTH; k++) r_vd_idx[k] <= '0;
        end else if (bus.flush) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
            r_valid <= '0;
            r_done  <= '0;
        end else begin
            if (bus.wb_valid && r_valid[bus.wb_idx]) r_done[bus.wb_idx] <= 1'b1;
            if (w_alloc) begin
                r_valid[r_tail]  <= 1'b1;
                r_done[r_tail]   <= 1'b0;
                r_vd_wr[r_tail]  <= bus.disp_vd_wr;
                r_vd_idx[r_tail] <= bus.disp_vd_idx;
                r_tail           <= r_tail + 3'd1;
            end
            if (w_retire) begin
                r_valid[r_head] <= 1'b0;
                r_head          <= r_head + 3'd1;
            end
            r_count <= r_count + 4'(w_alloc) - 4'(w_retire);
        end
    end
endmodule

// File: tb/tb_rvv_backend_dispatch_raw_tracker.sv
// tb_rvv_backend_dispatch_raw_tracker: directed scenario checks of the RAW tracker
module tb_rvv_backend_dispatch_raw_tracker;
    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    rvv_backend_dispatch_raw_tracker_if #(.ROB_DEPTH(8), .VREG_W(5)) bus ();

    rvv_backend_dispatch_raw_tracker #(.ROB_DEPTH(8), .VREG_W(5)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    task automatic clear_inputs();
        bus.flush = 0; bus.disp_valid = 0; bus.disp_vd_wr = 0; bus.disp_vd_rd = 0;
        bus.disp_vs1_idx = '0; bus.disp_vs2_idx = '0; bus.disp_vd_idx = '0;
        bus.disp_vs1_en = 0; bus.disp_vs2_en = 0; bus.disp_v0_en = 0;
        bus.wb_valid = 0; bus.wb_idx = '0; bus.retire_ready = 0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        clear_inputs();
        rst_n = 0;
        #3;
        rst_n = 1;
        tick();
    endtask

    task automatic offer(input logic [4:0] vd, input logic wr);
        bus.disp_valid = 1; bus.disp_vd_idx = vd; bus.disp_vd_wr = wr;
        #1;
    endtask

    task automatic push(input logic [4:0] vd, input logic wr);
        offer(vd, wr);
        tick();
        bus.disp_valid = 0;
    endtask

    task automatic wb(input logic [2:0] e);
        bus.wb_valid = 1; bus.wb_idx = e;
        tick();
        bus.wb_valid = 0;
    endtask

    task automatic test_reset();
        do_reset();
        bus.disp_vs1_en = 1; bus.disp_vs2_en = 1; bus.disp_vd_rd = 1; bus.disp_v0_en = 1;
        #1;
        checks++; if (bus.empty !== 1'b1) begin errors++; $display("FAIL reset_empty got %b exp 1", bus.empty); end
        checks++; if (bus.full !== 1'b0) begin errors++; $display("FAIL reset_full got %b exp 0", bus.full); end
        checks++; if (bus.count !== 4'd0) begin errors++; $display("FAIL reset_count got %0d exp 0", bus.count); end
        checks++; if (bus.retire_valid !== 1'b0) begin errors++; $display("FAIL reset_retire_valid got %b exp 0", bus.retire_valid); end
        checks++; if (bus.disp_ready !== 1'b1) begin errors++; $display("FAIL reset_disp_ready got %b exp 1", bus.disp_ready); end
        checks++; if ({bus.vs1_hit, bus.vs2_hit, bus.vd_hit, bus.v0_hit} !== 32'h0) begin errors++; $display("FAIL reset_hits got %h exp 0", {bus.vs1_hit, bus.vs2_hit, bus.vd_hit, bus.v0_hit}); end
        checks++; if ({bus.disp_rob_idx, bus.retire_idx, bus.retire_vd_idx, bus.retire_vd_wr} !== 12'h0) begin errors++; $display("FAIL reset_idx got %h exp 0", {bus.disp_rob_idx, bus.retire_idx, bus.retire_vd_idx, bus.retire_vd_wr}); end
        clear_inputs();
    endtask

    task automatic test_basic();
        do_reset();
        for (int i = 0; i < 3; i++) begin
            offer(5'(i + 1), 1'b1);
            checks++; if (bus.disp_rob_idx !== 3'(i)) begin errors++; $display("FAIL basic_rob_idx%0d got %0d exp %0d", i, bus.disp_rob_idx, i); end
            tick();
        end
        bus.disp_valid = 0;
        #1;
        checks++; if (bus.count !== 4'd3) begin errors++; $display("FAIL basic_count got %0d exp 3", bus.count); end
        wb(0); wb(1); wb(2);
        bus.retire_ready = 1;
        #1;
        for (int i = 0; i < 3; i++) begin
            checks++; if (bus.retire_valid !== 1'b1 || bus.retire_idx !== 3'(i) || bus.retire_vd_idx !== 5'(i + 1)) begin
                errors++; $display("FAIL basic_retire%0d got v=%b idx=%0d vd=%0d exp v=1 idx=%0d vd=%0d", i, bus.retire_valid, bus.retire_idx, bus.retire_vd_idx, i, i + 1);
            end
            tick();
        end
        checks++; if (bus.empty !== 1'b1 || bus.retire_valid !== 1'b0) begin errors++; $display("FAIL basic_empty got e=%b rv=%b exp e=1 rv=0", bus.empty, bus.retire_valid); end
        clear_inputs();
    endtask

    task automatic test_youngest();
        do_reset();
        push(5, 1); push(6, 1); push(5, 1);
        wb(0); wb(1); wb(2);
        bus.disp_vs2_idx = 5; bus.disp_vs2_en = 1;
        offer(9, 1);
        checks++; if (bus.vs2_hit !== 8'b0000_0100) begin errors++; $display("FAIL youngest_vs2_hit got %b exp 00000100", bus.vs2_hit); end
        checks++; if (bus.disp_ready !== 1'b1) begin errors++; $display("FAIL youngest_ready got %b exp 1", bus.disp_ready); end
        checks++; if (bus.vs1_hit !== 8'h00) begin errors++; $display("FAIL youngest_vs1_off got %b exp 0", bus.vs1_hit); end
        clear_inputs();
    endtask

    task automatic test_raw_stall();
        do_reset();
        push(7, 1); wb(0); push(7, 1);
        bus.disp_vs1_idx = 7; bus.disp_vs1_en = 1;
        offer(8, 1);
        checks++; if (bus.vs1_hit !== 8'b0000_0010) begin errors++; $display("FAIL stall_vs1_hit got %b exp 00000010", bus.vs1_hit); end
        checks++; if (bus.disp_ready !== 1'b0) begin errors++; $display("FAIL stall_ready got %b exp 0", bus.disp_ready); end
        tick();
        checks++; if (bus.count !== 4'd2) begin errors++; $display("FAIL stall_no_alloc got %0d exp 2", bus.count); end
        bus.wb_valid = 1; bus.wb_idx = 1;
        #1;
        checks++; if (bus.disp_ready !== 1'b0) begin errors++; $display("FAIL stall_same_cycle_wb got %b exp 0", bus.disp_ready); end
        tick();
        bus.wb_valid = 0;
        #1;
        checks++; if (bus.disp_ready !== 1'b1) begin errors++; $display("FAIL stall_release got %b exp 1", bus.disp_ready); end
        tick();
        checks++; if (bus.count !== 4'd3) begin errors++; $display("FAIL stall_alloc_after got %0d exp 3", bus.count); end
        clear_inputs();
    endtask

    task automatic test_same_cycle_wb();
        do_reset();
        offer(3, 1);
        bus.wb_valid = 1; bus.wb_idx = 0;
        tick();
        clear_inputs();
        #1;
        checks++; if (bus.retire_valid !== 1'b0 || bus.count !== 4'd1) begin errors++; $display("FAIL samewb_ignored got rv=%b cnt=%0d exp rv=0 cnt=1", bus.retire_valid, bus.count); end
        bus.disp_vs1_idx = 3; bus.disp_vs1_en = 1;
        #1;
        checks++; if (bus.disp_ready !== 1'b0 || bus.vs1_hit !== 8'h01) begin errors++; $display("FAIL samewb_stall got rdy=%b hit=%b exp rdy=0 hit=00000001", bus.disp_ready, bus.vs1_hit); end
        clear_inputs();
    endtask

    task automatic test_full_wrap();
        do_reset();
        for (int i = 0; i < 8; i++) push(5'(10 + i), 1'b1);
        offer(20, 1);
        checks++; if (bus.full !== 1'b1 || bus.count !== 4'd8) begin errors++; $display("FAIL full_flag got f=%b cnt=%0d exp f=1 cnt=8", bus.full, bus.count); end
        checks++; if (bus.disp_ready !== 1'b0) begin errors++; $display("FAIL full_ready got %b exp 0", bus.disp_ready); end
        bus.disp_valid = 0;
        wb(0); wb(1);
        bus.retire_ready = 1;
        offer(20, 1);
        checks++; if (bus.retire_valid !== 1'b1 || bus.disp_ready !== 1'b0) begin errors++; $display("FAIL full_retire_no_reuse got rv=%b rdy=%b exp rv=1 rdy=0", bus.retire_valid, bus.disp_ready); end
        tick();
        checks++; if (bus.count !== 4'd7 || bus.disp_ready !== 1'b1 || bus.disp_rob_idx !== 3'd0) begin errors++; $display("FAIL wrap_first got cnt=%0d rdy=%b idx=%0d exp cnt=7 rdy=1 idx=0", bus.count, bus.disp_ready, bus.disp_rob_idx); end
        tick();
        bus.retire_ready = 0;
        offer(21, 1);
        checks++; if (bus.disp_rob_idx !== 3'd1 || bus.count !== 4'd7) begin errors++; $display("FAIL wrap_second got idx=%0d cnt=%0d exp idx=1 cnt=7", bus.disp_rob_idx, bus.count); end
        tick();
        bus.disp_valid = 0;
        bus.disp_vs1_idx = 21; bus.disp_vs1_en = 1;
        bus.disp_vs2_idx = 20; bus.disp_vs2_en = 1;
        #1;
        checks++; if (bus.vs1_hit !== 8'h80) begin errors++; $display("FAIL wrap_slot7 got %b exp 10000000", bus.vs1_hit); end
        checks++; if (bus.vs2_hit !== 8'h40) begin errors++; $display("FAIL wrap_slot6 got %b exp 01000000", bus.vs2_hit); end
        checks++; if (bus.full !== 1'b1 || bus.retire_idx !== 3'd2) begin errors++; $display("FAIL wrap_head got f=%b head=%0d exp f=1 head=2", bus.full, bus.retire_idx); end
        clear_inputs();
    endtask

    task automatic test_mask();
        do_reset();
        push(0, 0);
        bus.disp_v0_en = 1;
        #1;
        checks++; if (bus.v0_hit !== 8'h00 || bus.disp_ready !== 1'b1) begin errors++; $display("FAIL mask_store got hit=%b rdy=%b exp hit=0 rdy=1", bus.v0_hit, bus.disp_ready); end
        bus.disp_v0_en = 0;
        push(0, 1);
        bus.disp_v0_en = 1; bus.disp_vd_idx = 0; bus.disp_vd_rd = 1;
        #1;
        checks++; if (bus.v0_hit !== 8'h02 || bus.disp_ready !== 1'b0) begin errors++; $display("FAIL mask_writer got hit=%b rdy=%b exp hit=00000010 rdy=0", bus.v0_hit, bus.disp_ready); end
        checks++; if (bus.vd_hit !== 8'h02) begin errors++; $display("FAIL mask_vd_hit got %b exp 00000010", bus.vd_hit); end
        clear_inputs();
    endtask

    task automatic test_flush();
        do_reset();
        for (int i = 0; i < 5; i++) push(5'(i + 1), 1'b1);
        wb(0);
        bus.flush = 1; bus.wb_valid = 1; bus.wb_idx = 1; bus.retire_ready = 1;
        offer(9, 1);
        checks++; if (bus.disp_ready !== 1'b0) begin errors++; $display("FAIL flush_ready got %b exp 0", bus.disp_ready); end
        tick();
        clear_inputs();
        #1;
        checks++; if (bus.count !== 4'd0 || bus.empty !== 1'b1 || bus.disp_rob_idx !== 3'd0 || bus.retire_valid !== 1'b0) begin
            errors++; $display("FAIL flush_state got cnt=%0d e=%b idx=%0d rv=%b exp cnt=0 e=1 idx=0 rv=0", bus.count, bus.empty, bus.disp_rob_idx, bus.retire_valid);
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        push(4, 1); push(6, 1); wb(0);
        #1;
        rst_n = 0;
        #1;
        checks++; if (bus.count !== 4'd0 || bus.empty !== 1'b1 || bus.retire_valid !== 1'b0 || bus.disp_rob_idx !== 3'd0 || bus.retire_vd_idx !== 5'd0) begin
            errors++; $display("FAIL async_reset got cnt=%0d e=%b rv=%b idx=%0d vd=%0d exp 0 1 0 0 0", bus.count, bus.empty, bus.retire_valid, bus.disp_rob_idx, bus.retire_vd_idx);
        end
        rst_n = 1;
        tick();
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst_n  = 0;
        clear_inputs();
        test_reset();
        test_basic();
        test_youngest();
        test_raw_stall();
        test_same_cycle_wb();
        test_full_wrap();
        test_mask();
        test_flush();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/rvv_backend_dispatch_raw_tracker.md
# rvv_backend_dispatch_raw_tracker

In-order RAW hazard tracker and ROB slot allocator for the RVV backend dispatch stage. It keeps one record per ROB entry: destination vreg, write-enable and writeback-done. It returns a ROB index to each dispatched uop, retires entries in order, and flushes on trap. For each incoming uop it produces the age-ordered one-hot `vs1/vs2/vd/v0` hit vectors consumed by the dispatch operand bypass mux. It stalls dispatch whenever the selected producer has not yet written back.

## Interface
- `ROB_DEPTH`, default 8: ROB entries. It is fixed at 8 because the bypass mux is hard-coded for 8 slots.
- `VREG_W`, default 5: vector register index width.
- `clk` input 1: clock, rising edge.
- `rst_n` input 1: reset, asynchronous, active-low.
- `flush` input 1: trap flush. Clears all entries.
- `disp_valid` input 1: a uop is offered for dispatch.
- `disp_ready` output 1: the uop is accepted this cycle.
- `disp_vs1_idx`, `disp_vs2_idx`, `disp_vd_idx` input `VREG_W`: source and destination register indices.
- `disp_vs1_en`, `disp_vs2_en` input 1: the uop reads `vs1`/`vs2`.
- `disp_vd_rd` input 1: the uop reads old `vd` (for example, mac or undisturbed).
- `disp_v0_en` input 1: the uop reads the `v0` mask.
- `disp_vd_wr` input 1: the uop writes `vd`.
- `disp_rob_idx` output 3: ROB entry assigned to the accepted uop (the tail pointer).
- `vs1_hit`, `vs2_hit`, `vd_hit`, `v0_hit` output `ROB_DEPTH`: one-hot or zero. Bit k refers to age slot k, where slot 0 is the oldest valid entry.
- `wb_valid` input 1: a PU has written back an entry.
- `wb_idx` input 3: the ROB entry written back.
- `retire_valid` output 1: the head entry is valid and done.
- `retire_idx` output 3: head pointer.
- `retire_vd_idx` output `VREG_W`: destination of the head entry.
- `retire_vd_wr` output 1: write-enable of the head entry.
- `retire_ready` input 1: the retire stage accepts the head entry.
- `full`, `empty` output 1: occupancy flags.
- `count` output 4: number of valid entries, 0 to 8.

## Operation
- **State:** `head` (3 bits), `tail` (3 bits), `count` (4 bits), and per entry `valid`, `vd_idx`, `vd_wr`, `done`.
- **Pointers:** `head` and `tail` wrap modulo 8.
- **Age slots:** age slot k maps to entry `(head + k) mod 8`.
  - A slot is eligible only if k < `count`, `valid` is set and `vd_wr` is set.
- **Hit vectors** are combinational from current state and the dispatch inputs.
  - `vs1_hit[k]` = 1 only for the highest eligible k with `vd_idx == disp_vs1_idx`, and only when `disp_vs1_en` is set.
  - `vs2_hit` uses `disp_vs2_idx` with `disp_vs2_en`.
  - `vd_hit` uses `disp_vd_idx` with `disp_vd_rd`.
  - `v0_hit` uses index 0 with `disp_v0_en`.
  - Each vector is therefore one-hot (the youngest producer) or all-zero.
  - Hits are driven regardless of `disp_valid`.
- **raw_stall:** asserted when any asserted hit bit points to an entry with `done` = 0.
- **disp_ready:** `!full & !raw_stall & !flush`.
- **Allocate** on `disp_valid & disp_ready`:
  - `valid[tail]` = 1, `vd_idx` and `vd_wr` are captured, `done[tail]` = 0.
  - `tail` is incremented.
- **Writeback:** `wb_valid` sets `done[wb_idx]` only if `valid[wb_idx]` is set. A writeback to an invalid entry is ignored.
- **Retire:**
  - `retire_valid` = `valid[head] & done[head]` (registered state only).
  - On `retire_valid & retire_ready`: `valid[head]` = 0 and `head` is incremented.
- **count:** increments on allocate only, decrements on retire only, unchanged when both or neither occur.
- **full / empty:** `full` = (`count` == 8); `empty` = (`count` == 0).
- **Flush:** has priority over allocate, writeback and retire in the same cycle. All `valid` and `done` bits clear, `head` = `tail` = 0, `count` = 0.

## Timing
- **Reset values:**
  - `head` = `tail` = `count` = 0; all `valid`/`done` = 0.
  - `empty` = 1, `full` = 0, `retire_valid` = 0, all hits = 0.
  - `disp_ready` = 1 when not flushing.
  - `disp_rob_idx` = 0, `retire_idx` = 0, `retire_vd_idx` = 0, `retire_vd_wr` = 0.
- **Latency:**
  - Hits, `disp_ready` and `disp_rob_idx` are zero-latency, with no input-to-output register.
  - All state updates take effect on the next rising edge.
- **Writeback visibility:** writeback is not forwarded within a cycle. A stall on entry e drops the cycle after the edge that samples `wb_valid` with `wb_idx` = e. `retire_valid` for that entry rises at the same point.
- **Allocate and retire in the same cycle:**
  - When `full`, `disp_ready` = 0 even if a retire handshake occurs that cycle. There is no same-cycle slot reuse.
  - When not full, allocate and retire may occur together.
- **Same-entry writeback and allocate:** a `wb_valid` naming the entry being allocated in the same cycle is ignored, because that entry is not yet valid.
- **Reset assertion** mid-operation asynchronously clears all state. Outputs reach their reset values immediately.

## Test plan
- **Basic allocate and retire:** after reset, dispatch 3 uops writing v1, v2, v3.
  - Required: `disp_rob_idx` = 0, 1, 2 and `count` = 3.
  - Then write back entries 0–2 and hold `retire_ready` = 1. Required: `retire_idx` = 0, 1, 2 on consecutive cycles, then `empty` = 1.
- **Youngest-producer selection:** entries 0 and 2 both write v5, and both are done. Dispatch a uop with `vs2` = v5, `vs2_en` = 1.
  - Required: `vs2_hit` = 8'b0000_0100 and `disp_ready` = 1.
- **RAW stall:** the youngest producer of v7 is not done and `vs1` = v7.
  - Required: `disp_ready` = 0.
  - Apply `wb_valid` to that entry. Required: `disp_ready` = 1 on the following cycle, not the same cycle.
- **Full and wrap-around:** fill 8 entries, so `full` = 1 and `disp_ready` = 0, even with a same-cycle retire.
  - Retire 2 entries, then dispatch 2 more. Required: `disp_rob_idx` = 0, 1 (wrapped).
  - With `head` = 2, the entry at index 1 maps to age slot 7, and a hit on it yields hit bit 7.
- **Mask and non-writing uops:**
  - A store (`vd_wr` = 0) with `vd` = v0 occupies a slot but produces no `v0_hit`.
  - A later uop writing v0 followed by a uop with `v0_en` = 1 yields a `v0_hit` on that writer's slot.
- **Flush:** with 5 entries in flight, assert `flush` together with `disp_valid`, `wb_valid` and `retire_ready`.
  - Required: `disp_ready` = 0 that cycle; the next cycle shows `count` = 0, `empty` = 1 and `disp_rob_idx` = 0.
  - Also assert `rst_n` low mid-stream. Required: all outputs return to reset values without waiting for a clock edge.
